spi_ip_shift_engine: RTL and testbench
======================================

Name: spi_ip_shift_engine

Overview:
Master-mode SPI serializer that consumes the configuration, TX buffer and CRC controls produced by the SPI host interface. It returns RX data, flag set pulses and status to that interface. It generates SCK, MOSI and NSS from a PCLK-derived divider and supports CPOL/CPHA, 8/16-bit frames and an appended CRC frame. It sits between the APB host interface and the chip pins.

Parameters:
- MAX_W, 16, maximum frame width; the CRC registers are also this width.

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  asynchronous active-high reset
- spi_en_i  in  1  enable; low aborts activity and clears the CRC registers
- cpol_i  in  1  SCK idle level
- cpha_i  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- clk_div_i  in  3  SCK period = 2^(clk_div_i+1) PCLK cycles
- frame16_i  in  1  1 = 16-bit frame, 0 = 8-bit frame
- ssm_i  in  1  software slave management select
- ssin_i  in  1  NSS level driven when ssm_i=1
- tx_buffer_i  in  16  word to transmit
- txe_flag_i  in  1  1 = TX buffer empty
- rxne_flag_i  in  1  1 = previous RX word not yet read
- crc_poly_i  in  16  CRC polynomial (low 8 bits used in 8-bit mode)
- crc_tx_flag_i  in  1  send the CRC frame after the current frame
- clear_crc_error_flag_i  in  1  clears crc_error_flag_o
- ovr_clear_i  in  1  clears ovr_flag_o
- miso_i  in  1  serial input
- sck_o  out  1  serial clock
- mosi_o  out  1  serial output
- ss_n_o  out  1  slave select, active low
- rx_buffer_o  out  16  last received frame, zero-extended in 8-bit mode
- crc_tx_data_o  out  16  running TX CRC
- crc_rx_data_o  out  16  running RX CRC
- set_txe_flag_o  out  1  one-cycle pulse: TX word consumed
- set_rxne_flag_o  out  1  one-cycle pulse: RX word available
- clear_crc_tx_flag_o  out  1  one-cycle pulse at the end of the CRC frame
- clear_crc_rx_flag_o  out  1  one-cycle pulse, same cycle as clear_crc_tx_flag_o
- busy_flag_o  out  1  frame in progress
- ovr_flag_o  out  1  sticky overrun flag
- crc_error_flag_o  out  1  sticky CRC mismatch flag

Behaviour:
- Reset values: sck_o=0, mosi_o=0, ss_n_o=1, rx_buffer_o=0, both CRC registers 0, all pulses 0, all flags 0, state IDLE.
- States:
  - IDLE -> LOAD when spi_en_i=1 and txe_flag_i=0.
  - LOAD (1 cycle):
    - latch cpol_i, cpha_i, clk_div_i and frame16_i; these hold until the next LOAD.
    - load the shift register from tx_buffer_i; pulse set_txe_flag_o.
    - busy_flag_o=1; ss_n_o=0.
  - SHIFT: 2N SCK edges (N = 8 or 16); one edge every 2^clk_div PCLK cycles.
  - DONE (1 cycle) -> CRC_LOAD if crc_tx_flag_i=1, else IDLE.
  - CRC_LOAD: load the shift register from crc_tx_data_o with no TXE pulse, then SHIFT, then CRC_DONE (1 cycle) -> IDLE.
- Bit order is MSB first.
  - CPHA=0: MOSI is valid from LOAD; sample on leading edges, shift on trailing edges.
  - CPHA=1: shift on leading edges, sample on trailing edges.
- SCK idles at the latched CPOL level; it follows cpol_i while in IDLE.
- DONE:
  - rx_buffer_o takes the received frame; pulse set_rxne_flag_o.
  - if rxne_flag_i=1 in the same cycle, set ovr_flag_o; rx_buffer_o is still overwritten.
- CRC update, per shifted bit b (TX bit or RX bit respectively):
  - crc = {crc[W-2:0],1'b0} ^ (crc[W-1]^b ? poly : 0), with W = frame width; upper bits are forced to 0 in 8-bit mode.
  - CRC registers do not update during the CRC frame itself.
- CRC_DONE:
  - if the received frame differs from crc_rx_data_o, set crc_error_flag_o.
  - pulse clear_crc_tx_flag_o and clear_crc_rx_flag_o; pulse set_rxne_flag_o.
  - clear both CRC registers the following cycle.
- Sticky flags: a set event wins over a same-cycle clear; otherwise ovr_clear_i or clear_crc_error_flag_i clears the flag.
- busy_flag_o=1 from LOAD through DONE/CRC_DONE inclusive. Minimum inter-frame gap is 2 PCLK cycles (DONE + IDLE).
- ss_n_o = ssin_i when ssm_i=1; otherwise ss_n_o = ~busy_flag_o, registered.
- spi_en_i low in any state:
  - next cycle goes to IDLE; sck_o = latched CPOL; ss_n_o=1; busy_flag_o=0.
  - no set/clear pulses are issued; CRC registers are cleared; rx_buffer_o and sticky flags are kept.
- PRESET asserted mid-frame returns all outputs to their reset values immediately (asynchronously).

Test Plan:
- Reset, spi_en=1, 8-bit, CPOL=0, CPHA=0, clk_div=0, tx=0xA5, miso looped to mosi -> SCK period 2 PCLK, 8 rising edges, mosi bits 1,0,1,0,0,1,0,1; rx_buffer=0x00A5; exactly one set_txe pulse and one set_rxne pulse.
- 16-bit, CPOL=1, CPHA=1, clk_div=2, tx=0x8001, miso tied to 1 -> SCK period 8 PCLK, idle high, 16 periods; rx_buffer=0xFFFF; busy low afterwards.
- Two frames back-to-back; rxne_flag_i held at 1 across the second DONE -> ovr_flag=1; ovr_clear pulse -> 0.
- 8-bit loopback, poly=0x07, tx=0x01, then crc_tx_flag=1 -> crc_tx_data=0x07 after frame 1; second frame sends 0x07; crc_error=0; clear_crc_tx/rx pulse; CRC registers return to 0.
- Same sequence with miso forced to 0 during the CRC frame -> crc_error_flag=1; clear_crc_error_flag_i -> 0.
- spi_en dropped after 3 SCK edges -> IDLE next cycle; ss_n=1; sck=CPOL; no rxne pulse; rx_buffer unchanged.

Source files
------------

// File: rtl/spi_ip_shift_engine.sv
// Master-mode SPI shift engine: frames TX words onto SCK/MOSI/NSS, captures MISO,
// keeps running TX/RX CRCs and can append a CRC frame after a data frame.
module spi_ip_shift_engine #(
    parameter int unsigned MAX_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             spi_en_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic [2:0]       clk_div_i,
    input  logic             frame16_i,
    input  logic             ssm_i,
    input  logic             ssin_i,
    input  logic [MAX_W-1:0] tx_buffer_i,
    input  logic             txe_flag_i,
    input  logic             rxne_flag_i,
    input  logic [MAX_W-1:0] crc_poly_i,
    input  logic             crc_tx_flag_i,
    input  logic             clear_crc_error_flag_i,
    input  logic             ovr_clear_i,
    input  logic             miso_i,
    output logic             sck_o,
    output logic             mosi_o,
    output logic             ss_n_o,
    output logic [MAX_W-1:0] rx_buffer_o,
    output logic [MAX_W-1:0] crc_tx_data_o,
    output logic [MAX_W-1:0] crc_rx_data_o,
    output logic             set_txe_flag_o,
    output logic             set_rxne_flag_o,
    output logic             clear_crc_tx_flag_o,
    output logic             clear_crc_rx_flag_o,
    output logic             busy_flag_o,
    output logic             ovr_flag_o,
    output logic             crc_error_flag_o
);
    localparam int unsigned EW = $clog2(2 * MAX_W);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StDone, StCrcLoad, StCrcDone} state_e;

    state_e           state_q;
    logic             cpol_q, cpha_q, f16_q, in_crc_q;
    logic [2:0]       div_q;
    logic [6:0]       cnt_q;
    logic [EW-1:0]    edge_q;
    logic [MAX_W-1:0] tx_sr_q, rx_sr_q, rx_buf_q, crc_tx_q, crc_rx_q;
    logic             sck_q, mosi_q, busy_q, ovr_q, crc_err_q;
    logic             set_txe_q, set_rxne_q, clr_crc_q;

    logic [6:0]       div_max;
    logic             tick, sample_edge, shift_edge, last_edge, tx_msb;
    logic [MAX_W-1:0] rx_next, load_word, tx_load;
    logic             load_f16, load_cpha, load_mosi;

    function automatic logic [MAX_W-1:0] crc_step(input logic [MAX_W-1:0] crc, input logic b,
                                                  input logic [MAX_W-1:0] poly, input logic wide);
        if (wide) begin
            return {crc[MAX_W-2:0], 1'b0} ^ ((crc[MAX_W-1] ^ b) ? poly : '0);
        end
        return {{(MAX_W-8){1'b0}}, crc[6:0], 1'b0} ^
               ((crc[7] ^ b) ? {{(MAX_W-8){1'b0}}, poly[7:0]} : '0);
    endfunction

    always_comb begin
        div_max     = (7'd1 << div_q) - 7'd1;
        tick        = (state_q == StShift) && (cnt_q == div_max);
        // Even edge index = leading edge; CPHA picks which of the pair samples.
        sample_edge = tick && (edge_q[0] == cpha_q);
        shift_edge  = tick && (edge_q[0] != cpha_q);
        last_edge   = edge_q == (f16_q ? EW'(2 * MAX_W - 1) : EW'(15));
        tx_msb      = f16_q ? tx_sr_q[MAX_W-1] : tx_sr_q[7];
        rx_next     = sample_edge ? {rx_sr_q[MAX_W-2:0], miso_i} : rx_sr_q;
        // Data frames load from the TX buffer with fresh config; CRC frames reuse the latched one.
        load_word   = (state_q == StDone) ? crc_tx_q : tx_buffer_i;
        load_f16    = (state_q == StDone) ? f16_q : frame16_i;
        load_cpha   = (state_q == StDone) ? cpha_q : cpha_i;
        load_mosi   = load_f16 ? load_word[MAX_W-1] : load_word[7];
        tx_load     = load_cpha ? load_word : {load_word[MAX_W-2:0], 1'b0};
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            f16_q     <= 1'b0;
            div_q     <= '0;
            in_crc_q  <= 1'b0;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_buf_q  <= '0;
            crc_tx_q  <= '0;
            crc_rx_q  <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            crc_err_q <= 1'b0;
            set_txe_q <= 1'b0;
            set_rxne_q <= 1'b0;
            clr_crc_q <= 1'b0;
        end else begin
            set_txe_q  <= 1'b0;
            set_rxne_q <= 1'b0;
            clr_crc_q  <= 1'b0;
            // Clears come first so a same-cycle set below takes priority.
            if (ovr_clear_i) ovr_q <= 1'b0;
            if (clear_crc_error_flag_i) crc_err_q <= 1'b0;
            if (!spi_en_i) begin
                state_q  <= StIdle;
                busy_q   <= 1'b0;
                in_crc_q <= 1'b0;
                crc_tx_q <= '0;
                crc_rx_q <= '0;
                sck_q    <= (state_q == StIdle) ? cpol_i : cpol_q;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        sck_q <= cpol_i;
                        if (!txe_flag_i) begin
                            cpol_q    <= cpol_i;
                            cpha_q    <= cpha_i;
                            div_q     <= clk_div_i;
                            f16_q     <= frame16_i;
                            tx_sr_q   <= tx_load;
                            if (!load_cpha) mosi_q <= load_mosi;
                            set_txe_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= StLoad;
                        end
                    end
                    StLoad, StCrcLoad: begin
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        state_q <= StShift;
                    end
                    StShift: begin
                        if (tick) begin
                            cnt_q  <= '0;
                            sck_q  <= ~sck_q;
                            edge_q <= edge_q + EW'(1);
                            if (sample_edge) begin
                                rx_sr_q <= rx_next;
                                if (!in_crc_q) begin
                                    crc_tx_q <= crc_step(crc_tx_q, mosi_q, crc_poly_i, f16_q);
                                    crc_rx_q <= crc_step(crc_rx_q, miso_i, crc_poly_i, f16_q);
                                end
                            end
                            if (shift_edge) begin
                                mosi_q  <= tx_msb;
                                tx_sr_q <= {tx_sr_q[MAX_W-2:0], 1'b0};
                            end
                            if (last_edge) begin
                                rx_buf_q   <= f16_q ? rx_next : {{(MAX_W-8){1'b0}}, rx_next[7:0]};
                                set_rxne_q <= 1'b1;
                                clr_crc_q  <= in_crc_q;
                                state_q    <= in_crc_q ? StCrcDone : StDone;
                            end
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                    StDone: begin
                        if (rxne_flag_i) ovr_q <= 1'b1;
                        if (crc_tx_flag_i) begin
                            in_crc_q <= 1'b1;
                            tx_sr_q  <= tx_load;
                            if (!load_cpha) mosi_q <= load_mosi;
                            state_q  <= StCrcLoad;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    StCrcDone: begin
                        if (rx_buf_q != crc_rx_q) crc_err_q <= 1'b1;
                        crc_tx_q <= '0;
                        crc_rx_q <= '0;
                        in_crc_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sck_o               = sck_q;
    assign mosi_o              = mosi_q;
    assign ss_n_o              = ssm_i ? ssin_i : ~busy_q;
    assign rx_buffer_o         = rx_buf_q;
    assign crc_tx_data_o       = crc_tx_q;
    assign crc_rx_data_o       = crc_rx_q;
    assign set_txe_flag_o      = set_txe_q;
    assign set_rxne_flag_o     = set_rxne_q;
    assign clear_crc_tx_flag_o = clr_crc_q;
    assign clear_crc_rx_flag_o = clr_crc_q;
    assign busy_flag_o         = busy_q;
    assign ovr_flag_o          = ovr_q;
    assign crc_error_flag_o    = crc_err_q;

endmodule

// File: tb/tb_spi_ip_shift_engine.sv
// Directed bench for spi_ip_shift_engine; RX words and MOSI bits are checked against
// scoreboard queues filled when each frame is launched.
module tb_spi_ip_shift_engine;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        spi_en_i, cpol_i, cpha_i, frame16_i, ssm_i, ssin_i;
    logic [2:0]  clk_div_i;
    logic [15:0] tx_buffer_i, crc_poly_i;
    logic        txe_flag_i, rxne_flag_i, crc_tx_flag_i, clear_crc_error_flag_i, ovr_clear_i;
    logic        miso_i;
    logic        sck_o, mosi_o, ss_n_o;
    logic [15:0] rx_buffer_o, crc_tx_data_o, crc_rx_data_o;
    logic        set_txe_flag_o, set_rxne_flag_o, clear_crc_tx_flag_o, clear_crc_rx_flag_o;
    logic        busy_flag_o, ovr_flag_o, crc_error_flag_o;

    logic        loop_en, miso_force;
    assign miso_i = loop_en ? mosi_o : miso_force;

    spi_ip_shift_engine #(.MAX_W(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .spi_en_i(spi_en_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
        .clk_div_i(clk_div_i), .frame16_i(frame16_i), .ssm_i(ssm_i), .ssin_i(ssin_i),
        .tx_buffer_i(tx_buffer_i), .txe_flag_i(txe_flag_i), .rxne_flag_i(rxne_flag_i),
        .crc_poly_i(crc_poly_i), .crc_tx_flag_i(crc_tx_flag_i),
        .clear_crc_error_flag_i(clear_crc_error_flag_i), .ovr_clear_i(ovr_clear_i),
        .miso_i(miso_i), .sck_o(sck_o), .mosi_o(mosi_o), .ss_n_o(ss_n_o),
        .rx_buffer_o(rx_buffer_o), .crc_tx_data_o(crc_tx_data_o), .crc_rx_data_o(crc_rx_data_o),
        .set_txe_flag_o(set_txe_flag_o), .set_rxne_flag_o(set_rxne_flag_o),
        .clear_crc_tx_flag_o(clear_crc_tx_flag_o), .clear_crc_rx_flag_o(clear_crc_rx_flag_o),
        .busy_flag_o(busy_flag_o), .ovr_flag_o(ovr_flag_o), .crc_error_flag_o(crc_error_flag_o)
    );

    always #5 PCLK = ~PCLK;

    int          n_vec = 0, n_err = 0;
    logic        mosi_exp[$];
    logic [15:0] rx_exp[$];
    int          txe_cnt = 0, rxne_cnt = 0, clr_cnt = 0, rise_cnt = 0;
    int          cyc = 0, last_rise = 0, last_period = 0;
    bit          have_prev = 0;
    logic        prev_sck = 1'b0;
    logic [15:0] last_rx = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Monitor: pops scoreboard entries on RXNE pulses and SCK rising edges within a frame.
    always @(negedge PCLK) begin
        cyc++;
        if (set_txe_flag_o) txe_cnt++;
        if (set_rxne_flag_o) begin
            rxne_cnt++;
            if (rx_exp.size() > 0) chk("rx_word", rx_buffer_o, rx_exp.pop_front());
            else chk("rx_unexpected_pulse", set_rxne_flag_o, 0);
        end
        if (clear_crc_tx_flag_o || clear_crc_rx_flag_o) begin
            clr_cnt++;
            chk("clr_crc_pair", clear_crc_tx_flag_o, clear_crc_rx_flag_o);
        end
        if (busy_flag_o && !prev_sck && sck_o) begin
            rise_cnt++;
            if (have_prev) last_period = cyc - last_rise;
            last_rise = cyc;
            have_prev = 1;
            if (mosi_exp.size() > 0) chk("mosi_bit", mosi_o, mosi_exp.pop_front());
        end
        if (!busy_flag_o) have_prev = 0;
        prev_sck = sck_o;
    end

    task automatic push_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) mosi_exp.push_back(w[i]);
    endtask

    task automatic push_rx(input logic [15:0] w);
        rx_exp.push_back(w);
        last_rx = w;
    endtask

    task automatic start_frame(input logic [15:0] w);
        bit got = 0;
        tx_buffer_i = w;
        txe_flag_i  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge PCLK);
            if (set_txe_flag_o) got = 1;
        end
        txe_flag_i = 1'b1;
        chk("txe_pulse_seen", got, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge PCLK);
            if (!busy_flag_o) done = 1;
        end
        chk("busy_drop_timeout", done, 1);
    endtask

    task automatic wait_rxne();
        bit got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge PCLK);
            if (set_rxne_flag_o) got = 1;
        end
        chk("rxne_timeout", got, 1);
    endtask

    initial begin
        int t0, r0, c0, edges;
        logic ps;
        PRESET = 1'b1; spi_en_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; frame16_i = 1'b0;
        ssm_i = 1'b0; ssin_i = 1'b1; clk_div_i = 3'd0; tx_buffer_i = 16'h0; txe_flag_i = 1'b1;
        rxne_flag_i = 1'b0; crc_poly_i = 16'h0; crc_tx_flag_i = 1'b0;
        clear_crc_error_flag_i = 1'b0; ovr_clear_i = 1'b0; loop_en = 1'b1; miso_force = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_sck", sck_o, 0);
        chk("rst_mosi", mosi_o, 0);
        chk("rst_ss_n", ss_n_o, 1);
        chk("rst_rx", rx_buffer_o, 0);
        chk("rst_crc_tx", crc_tx_data_o, 0);
        chk("rst_crc_rx", crc_rx_data_o, 0);
        chk("rst_busy", busy_flag_o, 0);
        chk("rst_flags", {ovr_flag_o, crc_error_flag_o}, 0);
        chk("rst_pulses", {set_txe_flag_o, set_rxne_flag_o, clear_crc_tx_flag_o}, 0);
        PRESET = 1'b0;
        spi_en_i = 1'b1;
        repeat (2) @(negedge PCLK);

        // 8-bit mode 0 loopback, fastest divider
        t0 = txe_cnt; r0 = rxne_cnt; rise_cnt = 0;
        push_bits(16'h00A5, 8); push_rx(16'h00A5);
        start_frame(16'h00A5);
        chk("t1_ss_active", ss_n_o, 0);
        wait_idle();
        chk("t1_rises", rise_cnt, 8);
        chk("t1_period", last_period, 2);
        chk("t1_txe_pulses", txe_cnt - t0, 1);
        chk("t1_rxne_pulses", rxne_cnt - r0, 1);
        chk("t1_rx_buf", rx_buffer_o, 16'h00A5);
        chk("t1_ss_idle", ss_n_o, 1);

        // 16-bit mode 3, divider 2, MISO high
        cpol_i = 1'b1; cpha_i = 1'b1; clk_div_i = 3'd2; frame16_i = 1'b1;
        loop_en = 1'b0; miso_force = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("t2_sck_idle_hi", sck_o, 1);
        rise_cnt = 0;
        push_bits(16'h8001, 16); push_rx(16'hFFFF);
        start_frame(16'h8001);
        wait_idle();
        chk("t2_rises", rise_cnt, 16);
        chk("t2_period", last_period, 8);
        chk("t2_busy", busy_flag_o, 0);
        chk("t2_sck_end", sck_o, 1);

        // Back-to-back frames, second DONE sees unread RXNE
        cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 3'd0; frame16_i = 1'b0; loop_en = 1'b1;
        push_rx(16'h003C);
        start_frame(16'h003C);
        wait_idle();
        chk("t3_no_ovr", ovr_flag_o, 0);
        rxne_flag_i = 1'b1;
        push_rx(16'h00C3);
        start_frame(16'h00C3);
        wait_idle();
        chk("t3_ovr_set", ovr_flag_o, 1);
        rxne_flag_i = 1'b0;
        ovr_clear_i = 1'b1;
        @(negedge PCLK);
        ovr_clear_i = 1'b0;
        @(negedge PCLK);
        chk("t3_ovr_clr", ovr_flag_o, 0);

        // CRC frame appended, matching loopback
        spi_en_i = 1'b0;
        @(negedge PCLK);
        spi_en_i = 1'b1;
        chk("t4_crc_cleared", crc_tx_data_o, 0);
        crc_poly_i = 16'h0007; crc_tx_flag_i = 1'b1;
        t0 = txe_cnt; c0 = clr_cnt;
        push_bits(16'h0001, 8); push_bits(16'h0007, 8);
        push_rx(16'h0001); push_rx(16'h0007);
        start_frame(16'h0001);
        wait_rxne();
        chk("t4_crc_tx", crc_tx_data_o, 16'h0007);
        chk("t4_crc_rx", crc_rx_data_o, 16'h0007);
        wait_idle();
        crc_tx_flag_i = 1'b0;
        chk("t4_crc_err", crc_error_flag_o, 0);
        chk("t4_clr_pulses", clr_cnt - c0, 1);
        chk("t4_txe_pulses", txe_cnt - t0, 1);
        chk("t4_crc_tx_zero", crc_tx_data_o, 0);
        chk("t4_crc_rx_zero", crc_rx_data_o, 0);

        // CRC frame corrupted on MISO
        crc_tx_flag_i = 1'b1;
        push_bits(16'h0001, 8); push_bits(16'h0007, 8);
        push_rx(16'h0001); push_rx(16'h0000);
        start_frame(16'h0001);
        wait_rxne();
        loop_en = 1'b0; miso_force = 1'b0;
        wait_idle();
        crc_tx_flag_i = 1'b0;
        chk("t5_crc_err_set", crc_error_flag_o, 1);
        clear_crc_error_flag_i = 1'b1;
        @(negedge PCLK);
        clear_crc_error_flag_i = 1'b0;
        @(negedge PCLK);
        chk("t5_crc_err_clr", crc_error_flag_o, 0);

        // Abort after three SCK edges
        loop_en = 1'b1; clk_div_i = 3'd1;
        r0 = rxne_cnt; c0 = clr_cnt;
        start_frame(16'h0055);
        ps = sck_o; edges = 0;
        for (int i = 0; i < 200 && edges < 3; i++) begin
            @(negedge PCLK);
            if (sck_o != ps) edges++;
            ps = sck_o;
        end
        chk("t6_edges", edges, 3);
        spi_en_i = 1'b0;
        @(negedge PCLK);
        chk("t6_busy", busy_flag_o, 0);
        chk("t6_ss_n", ss_n_o, 1);
        chk("t6_sck", sck_o, 0);
        chk("t6_crc_tx", crc_tx_data_o, 0);
        repeat (20) @(negedge PCLK);
        chk("t6_rx_kept", rx_buffer_o, last_rx);
        chk("t6_no_rxne", rxne_cnt - r0, 0);
        chk("t6_no_clr", clr_cnt - c0, 0);
        chk("sb_rx_drained", rx_exp.size(), 0);
        chk("sb_mosi_drained", mosi_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
